// File: rtl/nibble_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nibble_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Pass counter width; never narrower than one bit so WIDTH=4 still elaborates.
  function automatic int cnt_w(input int nibbles);
    return (nibbles < 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_fourbit_rp.sv
// fourbit_rp: 4-bit ripple-carry adder, the shared datapath of the sequencer.
// Latency: combinational. Backpressure: none.
// Flow control: none, pure logic.
module fourbit_rp
  import nibble_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic c;

  always_comb begin
    s = '0;
    c = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add via one 4-bit adder reused LSB nibble first; NIBBLE_SUB_EN adds a Sub port for A-B.
// Latency: Done rises NIBBLES+1 edges after the start edge (counting the start edge).
// Backpressure: Run is a level; DONE holds until Run drops, so a held Run never retriggers.
module nibble_serial_adder_ctrl
  import nibble_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef NIBBLE_SUB_EN
  input  logic             Sub,
`endif
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Busy,
  output logic             Done
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CW      = cnt_w(NIBBLES);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    a_sh, b_sh, res_nxt, b_ld;
  logic                carry, c_ld;
  logic [CW-1:0]       count;
  logic [NIBBLE_W-1:0] add_s;
  logic                add_c;
  logic                load, step, finish, last;

`ifdef NIBBLE_SUB_EN
  // Subtract is A + ~B + 1; the incoming Cin is deliberately dropped.
  assign b_ld = Sub ? ~B : B;
  assign c_ld = Sub ? 1'b1 : Cin;
`else
  assign b_ld = B;
  assign c_ld = Cin;
`endif

  assign last = (count == CW'(NIBBLES - 1));

  fourbit_rp u_add (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .cin  (carry),
    .s    (add_s),
    .cout (add_c)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        if (Run) begin
          load      = 1'b1;
          state_nxt = ADD;
        end
      end
      ADD: begin
        Busy = 1'b1;
        step = 1'b1;
        if (last) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        Done = 1'b1;
        if (!Run) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Result nibbles enter at the top and drift down, so the final pass completes the word.
  if (WIDTH > NIBBLE_W) begin : g_res
    logic [WIDTH-NIBBLE_W-1:0] res_sh;
    assign res_nxt = {add_s, res_sh};
    always_ff @(posedge Clk) begin
      if (!Reset)    res_sh <= '0;
      else if (step) res_sh <= res_nxt[WIDTH-1:NIBBLE_W];
    end
  end else begin : g_res_single
    assign res_nxt = add_s;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      count <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
    end else begin
      if (load) begin
        a_sh  <= A;
        b_sh  <= b_ld;
        carry <= c_ld;
        count <= '0;
      end else if (step) begin
        a_sh  <= a_sh >> NIBBLE_W;
        b_sh  <= b_sh >> NIBBLE_W;
        carry <= add_c;
        count <= count + 1'b1;
      end
      if (finish) begin
        Sum  <= res_nxt;
        Cout <= add_c;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: WIDTH=16 and WIDTH=4 instances, vector table plus random ops.
module tb_nibble_serial_adder_ctrl;

  logic        Clk   = 1'b0;
  logic        Reset = 1'b0;
  logic        Run   = 1'b0;
  logic [15:0] A     = '0;
  logic [15:0] B     = '0;
  logic        Cin   = 1'b0;
  logic [15:0] Sum;
  logic        Cout, Busy, Done;

  logic        Run4 = 1'b0;
  logic [3:0]  A4   = '0;
  logic [3:0]  B4   = '0;
  logic        Cin4 = 1'b0;
  logic [3:0]  Sum4;
  logic        Cout4, Busy4, Done4;

`ifdef NIBBLE_SUB_EN
  logic Sub  = 1'b0;
  logic Sub4 = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  nibble_serial_adder_ctrl #(.WIDTH(16)) u_dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .A(A), .B(B), .Cin(Cin),
`ifdef NIBBLE_SUB_EN
    .Sub(Sub),
`endif
    .Sum(Sum), .Cout(Cout), .Busy(Busy), .Done(Done)
  );

  nibble_serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .Run(Run4), .A(A4), .B(B4), .Cin(Cin4),
`ifdef NIBBLE_SUB_EN
    .Sub(Sub4),
`endif
    .Sum(Sum4), .Cout(Cout4), .Busy(Busy4), .Done(Done4)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation the caller asked for.
  function automatic logic [16:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + 17'd1;
    return {1'b0, a} + {1'b0, b} + {16'd0, cin};
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] es;
    logic        ec;
  } vec_t;

  // One full operation on the 16-bit instance, Run pulsed for the start edge only.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic sub, input logic [15:0] es, input logic ec);
    logic [15:0] prev;
    int dedge, busyn, moved;
    prev  = Sum;
    dedge = 0;
    busyn = 0;
    moved = 0;
    @(negedge Clk);
    A = a; B = b; Cin = cin;
`ifdef NIBBLE_SUB_EN
    Sub = sub;
`else
    if (sub) $display("note: subtract requested in add-only build");
`endif
    Run = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (k == 1) begin
        Run = 1'b0;
        A   = 16'($urandom);
        B   = 16'($urandom);
        Cin = 1'($urandom);
      end
      if (Busy) busyn++;
      if (Busy && Sum !== prev) moved++;
      if (Done) begin
        dedge = k;
        break;
      end
    end
    chk("sum", 32'(Sum), 32'(es));
    chk("cout", 32'(Cout), 32'(ec));
    chk("done_edge", 32'(dedge), 32'd5);
    chk("busy_cycles", 32'(busyn), 32'd4);
    chk("sum_stable_in_add", 32'(moved), 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    chk("idle_after_release", 32'({Done, Busy}), 32'd0);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] exp;
    int dedge;
    exp   = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    dedge = 0;
    @(negedge Clk);
    A4 = a; B4 = b; Cin4 = cin; Run4 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (k == 1) Run4 = 1'b0;
      if (Done4) begin
        dedge = k;
        break;
      end
    end
    chk("w4_sum", 32'(Sum4), 32'(exp[3:0]));
    chk("w4_cout", 32'(Cout4), 32'(exp[4]));
    chk("w4_done_edge", 32'(dedge), 32'd2);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    int rises, busyn;
    logic prevd;
    logic [15:0] ra, rb;
    logic rc, rs;
    logic [16:0] m;

    tbl.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
    tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    tbl.push_back('{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0});
    tbl.push_back('{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1});
    tbl.push_back('{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0});
`ifdef NIBBLE_SUB_EN
    tbl.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
    tbl.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
    tbl.push_back('{16'h0007, 16'h0005, 1'b0, 1'b0, 16'h000C, 1'b0});
`endif

    // Reset state
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_sum", 32'(Sum), 32'd0);
    chk("reset_cout_busy_done", 32'({Cout, Busy, Done}), 32'd0);
    chk("reset_w4", 32'({Sum4, Cout4, Busy4, Done4}), 32'd0);
    Reset = 1'b1;

    foreach (tbl[i]) op16(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].es, tbl[i].ec);

    // Run held high: single completion, operand change mid-add ignored
    @(negedge Clk);
    A = 16'h0003; B = 16'h0004; Cin = 1'b0; Run = 1'b1;
`ifdef NIBBLE_SUB_EN
    Sub = 1'b0;
`endif
    rises = 0; busyn = 0; prevd = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (k == 2) A = 16'hAAAA;
      if (Done && !prevd) rises++;
      prevd = Done;
      if (Busy) busyn++;
    end
    chk("held_completions", 32'(rises), 32'd1);
    chk("held_busy_cycles", 32'(busyn), 32'd4);
    chk("held_sum", 32'(Sum), 32'h0007);
    chk("held_done", 32'(Done), 32'd1);
    Run = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk("release_to_idle", 32'({Done, Busy}), 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    chk("stay_idle", 32'({Done, Busy}), 32'd0);

    // Reset in the second ADD cycle aborts the operation
    A = 16'hFFFF; B = 16'h0001; Cin = 1'b0; Run = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Run = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk("abort_in_add", 32'(Busy), 32'd1);
    Reset = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk("abort_sum", 32'(Sum), 32'd0);
    chk("abort_flags", 32'({Cout, Done, Busy}), 32'd0);
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("abort_stays_idle", 32'({Done, Busy}), 32'd0);
    op16(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);

    // Random operations against the arithmetic model
    for (int n = 0; n < 25; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
`ifdef NIBBLE_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      m = model16(ra, rb, rc, rs);
      op16(ra, rb, rc, rs, m[15:0], m[16]);
    end

    // Single-nibble instance
    op4(4'h9, 4'h8, 1'b1);
    for (int n = 0; n < 8; n++) op4(4'($urandom), 4'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
